button_press_unit: RTL
======================

Name: button_press_unit

Overview:
- Conditions a raw push-button into a clean single-cycle enable pulse.
- Its press_pulse output drives the button-press input of the register-enable 2-to-1 selector; the clock-divider tick drives the other input.
- Chain: 2-flop synchronizer, then press/release debounce FSM, then one-shot pulse with optional hold-to-repeat.
- press_count is a wrap-around count of emitted pulses, kept for debug.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized cycles needed to accept a press or a release. Must be >= 1.
- REPEAT_EN, 0: 1 enables auto-repeat pulses while the button is held.
- REPEAT_DELAY, 25000000: HELD cycles from HELD entry to the first repeat pulse. Must be >= 1.
- REPEAT_PERIOD, 5000000: HELD cycles between later repeat pulses. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- button  input  1  raw, asynchronous, active-high, bouncing button level.
- press_pulse  output  1  one-clock-wide enable pulse per accepted press (plus repeats).
- pressed  output  1  debounced button level.
- press_count  output  8  count of press_pulse assertions; wraps 255 -> 0.

Behaviour:
- Reset:
  - reset_n low clears at once, independent of clk: sync flops, FSM (to IDLE), debounce counter, repeat counter, all outputs.
  - Reset values: press_pulse=0, pressed=0, press_count=0.
  - Reset mid-debounce or mid-hold discards the press. No pulse is emitted during or after reset until a fresh press is debounced.
- Synchronizer:
  - button goes through sync1 then sync2; btn_s = sync2.
  - The FSM sees only btn_s.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES)+1.
- IDLE:
  - btn_s=1 -> PRESS_DB, counter cleared to 0.
- PRESS_DB:
  - btn_s=0 -> IDLE (bounce rejected, no pulse).
  - btn_s=1 and counter==DEBOUNCE_CYCLES-1 -> HELD.
  - Otherwise counter++.
- HELD:
  - press_pulse=1 for exactly the first cycle after entry from PRESS_DB.
  - btn_s=0 -> RELEASE_DB, counter cleared.
- RELEASE_DB:
  - btn_s=1 -> HELD. This re-entry emits no new pulse.
  - btn_s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE.
  - Otherwise counter++.
- pressed is 1 in HELD and RELEASE_DB, else 0. It is registered together with the state.
- Latency:
  - Edge 0 is the first rising edge that samples button=1 (button stays high).
  - FSM enters PRESS_DB at edge 2.
  - press_pulse is high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
  - pressed rises at the same edge as press_pulse.
  - Release is symmetric: pressed falls DEBOUNCE_CYCLES+2 edges after the first edge sampling button=0.
- Auto-repeat (REPEAT_EN=1 only):
  - Repeat counter clears on entry to HELD from PRESS_DB.
  - It counts only in HELD cycles and freezes during RELEASE_DB.
  - It is not cleared on a RELEASE_DB -> HELD bounce.
  - Taking the entry pulse as HELD cycle 0, pulses occur at HELD cycles REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2*REPEAT_PERIOD, and so on.
  - Each repeat pulse is one cycle wide.
- REPEAT_EN=0: exactly one pulse per debounced press.
- press_pulse is never high on two consecutive cycles. This holds even with REPEAT_PERIOD=1, where pulses alternate with low cycles.
  - Implementation: a repeat scheduled for the cycle right after a pulse is deferred one cycle.
  - All later repeat times are measured from the deferred pulse.
- press_count increments on every cycle press_pulse=1, modulo 256.
- DEBOUNCE_CYCLES=1: the FSM spends one cycle in PRESS_DB, so press_pulse appears at edge 3.

Test Plan:
- Clean press: D=4, REPEAT_EN=0; raise button before edge 0, hold 20 cycles, release, wait 20 -> press_pulse high edge 6 to 7 only; pressed high edge 6 until 6 edges after release sampling; press_count=1.
- Bounce reject: D=4; button high 3 cycles, low 1, high 2, low -> press_pulse never asserted, pressed stays 0, FSM back in IDLE.
- Release bounce: D=4; after HELD, button low 2 cycles, high 1, low 10 -> exactly 1 pulse total; pressed stays high through the bounce, then falls after 4 stable low cycles.
- Auto-repeat: D=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3; hold 30 HELD cycles -> pulses at HELD cycles 0, 10, 13, 16, 19, 22, 25, 28; press_count=8.
- Async reset mid-debounce: D=4; assert reset_n=0 between clock edges while in PRESS_DB -> outputs 0 immediately without waiting for an edge; after release of reset with button still high, full D+2 edge latency from the first sampling edge before the next pulse.
- Wrap: 256 clean presses -> press_count returns to 0; press_pulse never high on consecutive cycles throughout.

Source files
------------

// File: rtl/button_press_unit.sv
`timescale 1ns/1ps
// button_press_unit: turns a raw, bouncing push-button level into a clean
// one-clock enable pulse. The chain is a 2-flop synchronizer, then a
// press/release debounce FSM, then a one-shot with optional hold-to-repeat.
// press_count counts the pulses sent out (wraps at 256) for debug.
module button_press_unit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       button,
  output logic       press_pulse,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 2) + 1;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_DELAY  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD = REP_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // The repeat counter never has to pass its target by more than one, so
  // holding it at all-ones is only a guard against wrapping back to zero.
  function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
    return (v == {REP_W{1'b1}}) ? v : v + REP_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             first_q, first_d;
  logic             pulse_q, pulse_d;
  logic             pressed_q, pressed_d;
  logic [7:0]       count_q, count_d;

  logic             btn_s;
  logic             held_entry;
  logic [REP_W-1:0] rep_next;
  logic [REP_W-1:0] rep_target;

  assign btn_s = sync2_q;

  // Next-state, debounce counting, one-shot and repeat scheduling.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    first_d    = first_q;
    pulse_d    = 1'b0;
    held_entry = 1'b0;
    rep_next   = sat_inc(rep_cnt_q);
    rep_target = first_q ? REP_DELAY : REP_PERIOD;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          held_entry = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // rep_cnt counts HELD cycles since the last pulse; it is left alone in
    // RELEASE_DB so a release bounce does not disturb the repeat cadence.
    // A repeat that falls right after a pulse slips by one cycle and the
    // next interval is measured from where it actually fired.
    if (held_entry) begin
      pulse_d   = 1'b1;
      rep_cnt_d = '0;
      first_d   = 1'b1;
    end else if ((REPEAT_EN != 0) && (state_d == HELD)) begin
      if ((rep_next >= rep_target) && !pulse_q) begin
        pulse_d   = 1'b1;
        rep_cnt_d = '0;
        first_d   = 1'b0;
      end else begin
        rep_cnt_d = rep_next;
      end
    end

    pressed_d = (state_d == HELD) || (state_d == RELEASE_DB);
    count_d   = count_q + {7'd0, pulse_d};
  end

  // Synchronizer, FSM state and registered outputs; reset is asynchronous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
      first_q   <= 1'b0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      first_q   <= first_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
    end
  end

  assign press_pulse = pulse_q;
  assign pressed     = pressed_q;
  assign press_count = count_q;

endmodule
